sync_fifo_ctrl: RTL and testbench

- Single-clock synchronous FIFO: the storage/responder end of the fifo_if handshake.
- Accepts writer pushes (wr_en) and reader pops (rd_en). Drives full/empty so that the requesters can obey the rules "no wr_en while full" and "no rd_en while empty".
- Tolerates violations of those rules: a protocol-violating request is dropped and recorded in a sticky error flag. The existing fifo_if assertion module can bind to this block unchanged.

---
 rtl/sync_fifo_pkg.sv | 13 +
 rtl/sync_fifo_ctrl_if.sv | 34 +++
 rtl/sync_fifo_ctrl_ram.sv | 35 +++
 rtl/sync_fifo_ctrl.sv | 98 +++++++++
 tb/tb_sync_fifo_ctrl.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers for the synchronous FIFO controller.
package sync_fifo_pkg;

  // Pointer width: address bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int depth);
    return (depth > 0) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Handshake bundle between FIFO requesters (master) and the FIFO storage (slave).
interface fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = ptr_w(DEPTH);

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl_ram.sv
// Simple dual-port RAM: synchronous write, registered read with enable.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_reg;

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;
endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy, status flags and sticky error flags.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic   clk,
  input  logic   rst,
  fifo_if.slave  bus
);
  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_TH);
  localparam logic [PW-1:0] ONE      = PW'(1);

  generate
    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
      $fatal(1, "sync_fifo_ctrl: DEPTH must be a power of 2 and at least 4");
    end
  endgenerate

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic          rd_valid_reg, rd_valid_next;
  logic          overflow_reg, overflow_next;
  logic          underflow_reg, underflow_next;

  logic          full_w, empty_w;
  logic          push_ok, pop_ok;
  logic [PW-1:0] count_w;

  // Flags come only from registered pointers, so a same-cycle pop never frees room for a push.
  assign empty_w = (wr_ptr_reg == rd_ptr_reg);
  assign full_w  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign count_w = wr_ptr_reg - rd_ptr_reg;

  assign push_ok = bus.wr_en && !full_w;
  assign pop_ok  = bus.rd_en && !empty_w;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    rd_valid_next  = pop_ok;
    overflow_next  = overflow_reg  || (bus.wr_en && full_w);
    underflow_next = underflow_reg || (bus.rd_en && empty_w);
    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + ONE;
    end
    if (pop_ok) begin
      rd_ptr_next = rd_ptr_reg + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      rd_valid_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      rd_valid_reg  <= rd_valid_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (push_ok && !rst),
    .waddr (wr_ptr_reg[AW-1:0]),
    .wdata (bus.wr_data),
    .re    (pop_ok && !rst),
    .raddr (rd_ptr_reg[AW-1:0]),
    .rdata (bus.rd_data)
  );

  assign bus.rd_valid     = rd_valid_reg;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.count        = count_w;
  assign bus.almost_full  = (count_w >= AFULL_C);
  assign bus.almost_empty = (count_w <= AEMPTY_C);
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed and randomized checks of sync_fifo_ctrl against a queue-based reference model.
module tb_sync_fifo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_if #(.WIDTH(8), .DEPTH(16)) bus ();

  sync_fifo_ctrl #(
    .WIDTH(8), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] ref_q[$];
  logic [7:0] exp_q[$];
  bit         movf, munf;
  logic [7:0] last_data;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic check_flags();
    int n;
    n = ref_q.size();
    chk("count", 32'(bus.count), n);
    chk("full", 32'(bus.full), 32'(n == 16));
    chk("empty", 32'(bus.empty), 32'(n == 0));
    chk("almost_full", 32'(bus.almost_full), 32'(n >= 14));
    chk("almost_empty", 32'(bus.almost_empty), 32'(n <= 2));
    chk("overflow", 32'(bus.overflow), 32'(movf));
    chk("underflow", 32'(bus.underflow), 32'(munf));
    chk("not_full_and_empty", 32'(bus.full && bus.empty), 0);
  endtask

  task automatic step(input bit wr, input logic [7:0] d, input bit rd);
    bit push_ok, pop_ok;
    logic [7:0] exp_d;
    bus.wr_en   = wr;
    bus.wr_data = d;
    bus.rd_en   = rd;
    push_ok = wr && (ref_q.size() != 16);
    pop_ok  = rd && (ref_q.size() != 0);
    if (wr && !push_ok) movf = 1'b1;
    if (rd && !pop_ok)  munf = 1'b1;
    if (pop_ok) exp_q.push_back(ref_q.pop_front());
    if (push_ok) ref_q.push_back(d);
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk("rd_valid", 32'(bus.rd_valid), 32'(pop_ok));
    if (pop_ok) begin
      exp_d = exp_q.pop_front();
      chk("rd_data", 32'(bus.rd_data), 32'(exp_d));
      last_data = exp_d;
    end else begin
      chk("rd_data_hold", 32'(bus.rd_data), 32'(last_data));
    end
    check_flags();
    $display("step wr=%0d d=%02h rd=%0d -> count=%0d rd_valid=%0d rd_data=%02h",
             wr, d, rd, bus.count, bus.rd_valid, bus.rd_data);
  endtask

  task automatic do_reset(input bit req);
    rst       = 1'b1;
    bus.wr_en = req;
    bus.rd_en = req;
    bus.wr_data = 8'hEE;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    ref_q.delete();
    exp_q.delete();
    movf = 1'b0;
    munf = 1'b0;
    last_data = 8'h00;
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_rd_data", 32'(bus.rd_data), 0);
    check_flags();
    $display("reset req=%0d -> count=%0d empty=%0d", req, bus.count, bus.empty);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wr_data = 8'h00;
    movf = 1'b0;
    munf = 1'b0;
    last_data = 8'h00;

    do_reset(1'b0);

    // Underflow from reset: pop on empty is dropped.
    step(1'b0, 8'h00, 1'b1);
    do_reset(1'b0);

    // Fill then drain.
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);

    // Refill, overflow, then full with both requests.
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i + 8'h20), 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'hBB, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);

    // Empty with both requests: push taken, pop dropped, no bypass.
    do_reset(1'b0);
    step(1'b1, 8'h55, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Random traffic across pointer wraps, occupancy kept within 1..15.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 40; i++) begin
      bit wr, rd;
      int n;
      wr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      n  = ref_q.size();
      if (wr && !rd && n >= 15) wr = 1'b0;
      if (rd && !wr && n <= 1)  rd = 1'b0;
      step(wr, 8'($urandom_range(0, 255)), rd);
    end
    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1);

    // Reset mid-operation with a pop in the same cycle.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h70 + i), 1'b0);
    do_reset(1'b1);
    step(1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
